// File: rtl/mac_result_packer.sv
// Saturating result packer between the MAC d stream and the TCDM sink streamer.
// Optional ReLU stage: define MAC_RESULT_PACKER_RELU_EN to add the relu_i port.
module mac_result_packer #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SAT_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     len_i,
  input  logic [1:0]           mode_i,
`ifdef MAC_RESULT_PACKER_RELU_EN
  input  logic                 relu_i,
`endif
  input  logic                 d_valid_i,
  output logic                 d_ready_o,
  input  logic [31:0]          d_data_i,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  output logic [31:0]          q_data_o,
  output logic [3:0]           q_strb_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SAT_CNT_W-1:0] sat_cnt_o
);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_e;
  typedef enum logic [1:0] {MODE_32 = 2'd0, MODE_16 = 2'd1, MODE_8 = 2'd2} mode_e;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d, mode_in;
  logic [CNT_W-1:0]     len_q, len_d, cnt_q, cnt_d;
  logic [1:0]           lane_q, lane_d;
  logic [31:0]          stage_q, stage_d, q_data_q, q_data_d;
  logic [3:0]           q_strb_q, q_strb_d;
  logic                 q_valid_q, q_valid_d, done_q, done_d;
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic               start_job, accept, q_hs, last_elem, lane_last, complete, clipped;
  logic signed [31:0] elem, sat_v, max_v, min_v;
  logic [31:0]        lane_word;
  logic [3:0]         lane_strb;

  always_comb begin
    case (mode_i)
      2'd1:    mode_in = MODE_16;
      2'd2:    mode_in = MODE_8;
      default: mode_in = MODE_32;
    endcase
  end

`ifdef MAC_RESULT_PACKER_RELU_EN
  logic relu_q, relu_d;

  always_comb begin
    relu_d = relu_q;
    if (start_job) relu_d = relu_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      relu_q <= 1'b0;
    else if (clear_i) relu_q <= 1'b0;
    else              relu_q <= relu_d;
  end

  always_comb begin
    elem = d_data_i;
    if (relu_q && d_data_i[31]) elem = '0;
  end
`else
  always_comb begin
    elem = d_data_i;
  end
`endif

  // Clip bounds per precision; 32b bounds are the full range so nothing clips.
  always_comb begin
    case (mode_q)
      MODE_16: begin max_v = 32'sd32767; min_v = -32'sd32768; end
      MODE_8:  begin max_v = 32'sd127;   min_v = -32'sd128;   end
      default: begin max_v = 32'sh7FFF_FFFF; min_v = 32'sh8000_0000; end
    endcase
    clipped = (elem > max_v) || (elem < min_v);
    sat_v   = (elem > max_v) ? max_v : ((elem < min_v) ? min_v : elem);
  end

  always_comb begin
    case (mode_q)
      MODE_16: begin
        lane_word = {16'h0, sat_v[15:0]} << {lane_q[0], 4'h0};
        lane_strb = lane_q[0] ? 4'hF : 4'h3;
        lane_last = lane_q[0];
      end
      MODE_8: begin
        lane_word = {24'h0, sat_v[7:0]} << {lane_q, 3'h0};
        lane_strb = {lane_q == 2'd3, lane_q >= 2'd2, lane_q != 2'd0, 1'b1};
        lane_last = (lane_q == 2'd3);
      end
      default: begin
        lane_word = sat_v;
        lane_strb = 4'hF;
        lane_last = 1'b1;
      end
    endcase
    last_elem = (cnt_q == len_q - CNT_W'(1));
    complete  = lane_last || last_elem;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= IDLE;
    else if (clear_i) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      case (state_q)
        IDLE:    if (start_i && len_i != '0) state_d = PACK;
        PACK:    if (accept && last_elem) state_d = DRAIN;
        DRAIN:   if (q_hs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A completing element may load while the previous word is being accepted.
  always_comb begin
    start_job = enable_i && (state_q == IDLE) && start_i;
    d_ready_o = enable_i && (state_q == PACK) && (!complete || !q_valid_q || q_ready_i);
    accept    = d_valid_i && d_ready_o;
    q_hs      = enable_i && q_valid_q && q_ready_i;

    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    stage_d   = stage_q;
    q_data_d  = q_data_q;
    q_strb_d  = q_strb_q;
    q_valid_d = q_valid_q;
    sat_cnt_d = sat_cnt_q;
    done_d    = enable_i ? 1'b0 : done_q;

    if (start_job) begin
      mode_d    = mode_in;
      len_d     = len_i;
      cnt_d     = '0;
      lane_d    = '0;
      stage_d   = '0;
      sat_cnt_d = '0;
      done_d    = (len_i == '0);
    end
    if (q_hs) q_valid_d = 1'b0;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clipped && sat_cnt_q != '1) sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
      if (complete) begin
        q_data_d  = stage_q | lane_word;
        q_strb_d  = lane_strb;
        q_valid_d = 1'b1;
        lane_d    = '0;
        stage_d   = '0;
      end else begin
        stage_d = stage_q | lane_word;
        lane_d  = lane_q + 2'd1;
      end
    end
    if (state_q == DRAIN && q_hs) done_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= MODE_32;
      len_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      stage_q   <= '0;
      q_data_q  <= '0;
      q_strb_q  <= '0;
      q_valid_q <= 1'b0;
      sat_cnt_q <= '0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      mode_q    <= MODE_32;
      len_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      stage_q   <= '0;
      q_data_q  <= '0;
      q_strb_q  <= '0;
      q_valid_q <= 1'b0;
      sat_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      stage_q   <= stage_d;
      q_data_q  <= q_data_d;
      q_strb_q  <= q_strb_d;
      q_valid_q <= q_valid_d;
      sat_cnt_q <= sat_cnt_d;
      done_q    <= done_d;
    end
  end

  assign q_valid_o = q_valid_q;
  assign q_data_o  = q_data_q;
  assign q_strb_o  = q_strb_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule

// File: tb/tb_mac_result_packer.sv
// Directed scoreboard bench for mac_result_packer (default build, no ReLU).
module tb_mac_result_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, enable_i, start_i;
  logic [15:0] len_i;
  logic [1:0]  mode_i;
  logic        d_valid_i, d_ready_o;
  logic [31:0] d_data_i;
  logic        q_valid_o, q_ready_i;
  logic [31:0] q_data_o;
  logic [3:0]  q_strb_o;
  logic        busy_o, done_o;
  logic [15:0] sat_cnt_o;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic        tog = 1'b0;
  logic [35:0] sb[$];
  logic        stalled = 1'b0;
  logic [35:0] held = '0;
  logic [31:0] t3_data[8];

  mac_result_packer #(.CNT_W(16), .SAT_CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_data_i(d_data_i),
    .q_valid_o(q_valid_o), .q_ready_i(q_ready_i), .q_data_o(q_data_o), .q_strb_o(q_strb_o),
    .busy_o(busy_o), .done_o(done_o), .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks hold while stalled.
  always @(negedge clk_i) begin
    if (q_valid_o) begin
      if (stalled) chk("q_hold", 64'({q_strb_o, q_data_o}), 64'(held));
      if (q_ready_i && enable_i) begin
        if (sb.size() == 0) chk("q_extra_word", 64'(sb.size()), 64'd1);
        else begin
          chk("q_word", 64'({q_strb_o, q_data_o}), 64'(sb.pop_front()));
          hs_cyc = cyc;
        end
      end
      stalled = !(q_ready_i && enable_i);
      held    = {q_strb_o, q_data_o};
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (tog) q_ready_i = ~q_ready_i;
  endtask

  task automatic send(input logic [31:0] d);
    logic got;
    got = 1'b0;
    d_valid_i = 1'b1;
    d_data_i  = d;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk_i);
      got = d_ready_o;
      tick();
    end
    d_valid_i = 1'b0;
    chk("d_accept", 64'(got), 64'd1);
  endtask

  task automatic start_job(input logic [1:0] m, input logic [15:0] l);
    start_i = 1'b1;
    mode_i  = m;
    len_i   = l;
    tick();
    start_i = 1'b0;
    mode_i  = 2'd3;
    len_i   = '1;
  endtask

  task automatic wait_done();
    logic seen;
    int   dc;
    seen = 1'b0;
    dc   = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        dc   = cyc;
      end else tick();
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_latency", 64'(dc), 64'(hs_cyc + 1));
    chk("busy_at_done", 64'(busy_o), 64'd0);
    tick();
    @(negedge clk_i);
    chk("done_width", 64'(done_o), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b0; start_i = 1'b0;
    len_i = '0; mode_i = '0; d_valid_i = 1'b0; d_data_i = '0; q_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_q_valid", 64'(q_valid_o), 64'd0);
    chk("rst_q_data", 64'(q_data_o), 64'd0);
    chk("rst_q_strb", 64'(q_strb_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_sat", 64'(sat_cnt_o), 64'd0);
    chk("rst_d_ready", 64'(d_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    enable_i = 1'b1;
    tick();

    // 8b, four elements with two clipped
    q_ready_i = 1'b1;
    sb.push_back({4'hF, 32'h807F_FF01});
    start_job(2'd2, 16'd4);
    @(negedge clk_i);
    chk("t1_busy", 64'(busy_o), 64'd1);
    tick();
    send(32'd1); send(32'hFFFF_FFFF); send(32'd200); send(32'hFFFF_FED4);
    wait_done();
    chk("t1_sat", 64'(sat_cnt_o), 64'd2);

    // 16b, partial last word
    sb.push_back({4'hF, 32'h7FFF_1234});
    sb.push_back({4'h3, 32'h0000_FFFB});
    start_job(2'd1, 16'd3);
    send(32'h1234); send(32'h0007_FFF0); send(32'hFFFF_FFFB);
    wait_done();
    chk("t2_sat", 64'(sat_cnt_o), 64'd1);

    // 32b pass-through with toggling output ready
    t3_data[0] = 32'h8000_0000;
    t3_data[1] = 32'h7FFF_FFFF;
    for (int i = 2; i < 8; i++) t3_data[i] = $urandom;
    for (int i = 0; i < 8; i++) sb.push_back({4'hF, t3_data[i]});
    tog = 1'b1;
    start_job(2'd0, 16'd8);
    for (int i = 0; i < 8; i++) send(t3_data[i]);
    wait_done();
    tog = 1'b0;
    q_ready_i = 1'b1;
    chk("t3_sat", 64'(sat_cnt_o), 64'd0);

    // 8b backpressure, freeze while disabled, same-cycle recovery
    q_ready_i = 1'b0;
    sb.push_back({4'hF, 32'h1413_1211});
    sb.push_back({4'hF, 32'h1817_1615});
    start_job(2'd2, 16'd8);
    for (int i = 0; i < 7; i++) send(32'h11 + 32'(i));
    d_valid_i = 1'b1;
    d_data_i  = 32'h18;
    @(negedge clk_i);
    chk("t4_ready_blocked", 64'(d_ready_o), 64'd0);
    chk("t4_q_valid", 64'(q_valid_o), 64'd1);
    tick();
    enable_i  = 1'b0;
    q_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t4_ready_disabled", 64'(d_ready_o), 64'd0);
    chk("t4_valid_frozen", 64'(q_valid_o), 64'd1);
    tick();
    enable_i  = 1'b1;
    q_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t4_ready_still_blocked", 64'(d_ready_o), 64'd0);
    tick();
    q_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t4_ready_recover", 64'(d_ready_o), 64'd1);
    tick();
    d_valid_i = 1'b0;
    wait_done();
    chk("t4_sat", 64'(sat_cnt_o), 64'd0);

    // zero-length job
    start_i = 1'b1;
    mode_i  = 2'd0;
    len_i   = 16'd0;
    @(negedge clk_i);
    chk("t5_done_early", 64'(done_o), 64'd0);
    tick();
    start_i = 1'b0;
    @(negedge clk_i);
    chk("t5_done", 64'(done_o), 64'd1);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_no_valid", 64'(q_valid_o), 64'd0);
    tick();
    @(negedge clk_i);
    chk("t5_done_width", 64'(done_o), 64'd0);
    chk("t5_no_valid2", 64'(q_valid_o), 64'd0);
    tick();

    // synchronous clear mid-job
    start_job(2'd2, 16'd4);
    send(32'd300);
    @(negedge clk_i);
    chk("t6_sat_before", 64'(sat_cnt_o), 64'd1);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("t6_sat_cleared", 64'(sat_cnt_o), 64'd0);
    chk("t6_busy_cleared", 64'(busy_o), 64'd0);
    chk("t6_d_ready", 64'(d_ready_o), 64'd0);
    chk("t6_q_valid", 64'(q_valid_o), 64'd0);
    tick();

    // asynchronous reset mid-job, then a fresh single-element job
    start_job(2'd2, 16'd4);
    send(32'd5);
    send(32'd6);
    rst_ni = 1'b0;
    #1;
    chk("t7_busy", 64'(busy_o), 64'd0);
    chk("t7_q_valid", 64'(q_valid_o), 64'd0);
    chk("t7_q_data", 64'(q_data_o), 64'd0);
    chk("t7_q_strb", 64'(q_strb_o), 64'd0);
    chk("t7_done", 64'(done_o), 64'd0);
    chk("t7_d_ready", 64'(d_ready_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    sb.push_back({4'h1, 32'h0000_0007});
    start_job(2'd2, 16'd1);
    send(32'd7);
    wait_done();
    chk("t7_sat", 64'(sat_cnt_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
